// File: rtl/mult_req_arbiter.sv
// Round-robin front end that shares one multiplier among NUM_REQ requesters.
// Winner IDs go into an in-order tag FIFO so each returning product is routed back to its owner.
module mult_req_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int DIN_W           = 8,
   parameter int DOUT_W          = 2*DIN_W,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   input  logic [NUM_REQ*DIN_W-1:0] req_a_i,
   input  logic [NUM_REQ*DIN_W-1:0] req_b_i,
   output logic [NUM_REQ-1:0]       resp_valid_o,
   output logic [DOUT_W-1:0]        resp_product_o,
   output logic [DIN_W-1:0]         mult_a_o,
   output logic [DIN_W-1:0]         mult_b_o,
   output logic                     mult_valid_o,
   input  logic [DOUT_W-1:0]        mult_product_i,
   input  logic                     mult_product_valid_i,
   input  logic                     drain_i,
   output logic                     drained_o,
   output logic                     tag_err_o
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

   state_t             state, state_next;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    winner;
   logic               found;
   logic               handshake;
   logic               pop;
   logic [DIN_W-1:0]   sel_a, sel_b;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [ID_W-1:0]    tag_mem [MAX_OUTSTANDING];
   logic [NUM_REQ-1:0] pop_onehot;

   // Second pass overrides the first, so the lowest valid index at or above rr_ptr wins,
   // falling back to the lowest valid index overall when the search wraps.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (req_valid_i[i]) begin
            winner = ID_W'(i);
            found  = 1'b1;
         end
      end
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (req_valid_i[i] && (ID_W'(i) >= rr_ptr)) begin
            winner = ID_W'(i);
         end
      end
   end

   // drain_i gates ready directly so the cycle that requests a drain cannot sneak in an accept.
   always_comb begin
      req_ready_o = '0;
      if (rst_n && found && (state == RUN) && !drain_i &&
          (count < CNT_W'(MAX_OUTSTANDING))) begin
         req_ready_o[winner] = 1'b1;
      end
   end

   assign handshake = |(req_valid_i & req_ready_o);
   assign pop       = mult_product_valid_i && (count != '0);
   assign drained_o = (state == DRAINED);

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == winner) begin
            sel_a = req_a_i[i*DIN_W +: DIN_W];
            sel_b = req_b_i[i*DIN_W +: DIN_W];
         end
      end
   end

   always_comb begin
      pop_onehot = '0;
      pop_onehot[tag_mem[rd_ptr]] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr       <= '0;
         mult_a_o     <= '0;
         mult_b_o     <= '0;
         mult_valid_o <= 1'b0;
      end else begin
         mult_valid_o <= handshake;
         if (handshake) begin
            rr_ptr   <= (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);
            mult_a_o <= sel_a;
            mult_b_o <= sel_b;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (handshake) begin
         tag_mem[wr_ptr] <= winner;
      end
   end

   // Pointers wrap explicitly so depths that are not a power of two still work.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (handshake) begin
            wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : rd_ptr + PTR_W'(1);
         end
         if (handshake && !pop) begin
            count <= count + CNT_W'(1);
         end else if (!handshake && pop) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_o   <= '0;
         resp_product_o <= '0;
         tag_err_o      <= 1'b0;
      end else begin
         resp_valid_o <= pop ? pop_onehot : '0;
         if (pop) begin
            resp_product_o <= mult_product_i;
         end
         if (mult_product_valid_i && (count == '0)) begin
            tag_err_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         RUN: begin
            if (drain_i) state_next = DRAIN;
         end
         DRAIN: begin
            if (!drain_i) begin
               state_next = RUN;
            end else if ((count == '0) && !mult_product_valid_i) begin
               state_next = DRAINED;
            end
         end
         DRAINED: begin
            if (!drain_i) state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

endmodule

// File: tb/tb_mult_req_arbiter.sv
// Directed-vector bench for mult_req_arbiter; the bench itself plays the multiplier,
// returning hand-chosen products at hand-chosen cycles.
module tb_mult_req_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DIN_W   = 8;
   localparam int DOUT_W  = 16;
   localparam int MAX_OUT = 8;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*DIN_W-1:0] req_a;
   logic [NUM_REQ*DIN_W-1:0] req_b;
   logic [NUM_REQ-1:0]       resp_valid;
   logic [DOUT_W-1:0]        resp_product;
   logic [DIN_W-1:0]         mult_a;
   logic [DIN_W-1:0]         mult_b;
   logic                     mult_valid;
   logic [DOUT_W-1:0]        mult_product;
   logic                     mult_product_valid;
   logic                     drain;
   logic                     drained;
   logic                     tag_err;

   int assert_count = 0;
   int fail_count   = 0;

   mult_req_arbiter #(
      .NUM_REQ(NUM_REQ), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid_i(req_valid),
      .req_ready_o(req_ready),
      .req_a_i(req_a),
      .req_b_i(req_b),
      .resp_valid_o(resp_valid),
      .resp_product_o(resp_product),
      .mult_a_o(mult_a),
      .mult_b_o(mult_b),
      .mult_valid_o(mult_valid),
      .mult_product_i(mult_product),
      .mult_product_valid_i(mult_product_valid),
      .drain_i(drain),
      .drained_o(drained),
      .tag_err_o(tag_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assert_count++;
      if (got !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [NUM_REQ-1:0] valid,
                                input logic [NUM_REQ*DIN_W-1:0] a,
                                input logic [NUM_REQ*DIN_W-1:0] b,
                                input logic pv,
                                input logic [DOUT_W-1:0] prod,
                                input logic drn);
      req_valid          = valid;
      req_a              = a;
      req_b              = b;
      mult_product_valid = pv;
      mult_product       = prod;
      drain              = drn;
   endtask

   // Registered outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      applyStimulus('0, '0, '0, 1'b0, '0, 1'b0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, '0, 1'b0);
      #2;
      checkOutput("rst_ready",      32'(req_ready), 32'h0);
      checkOutput("rst_mult_valid", 32'(mult_valid), 32'h0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
      checkOutput("rst_drained",    32'(drained), 32'h0);
      checkOutput("rst_tag_err",    32'(tag_err), 32'h0);
      checkOutput("rst_mult_a",     32'(mult_a), 32'h0);
      step();
      rst_n = 1'b1;
      #1;
      checkOutput("first_grant", 32'(req_ready), 32'h1);

      $display("[TB] round robin, all requesters valid");
      for (int k = 0; k < 8; k++) begin
         if (k > 0) #1;
         checkOutput($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
         step();
         checkOutput($sformatf("rr_mult_a%0d", k), 32'(mult_a), 32'(10 * ((k % 4) + 1)));
         checkOutput($sformatf("rr_mult_valid%0d", k), 32'(mult_valid), 32'h1);
      end
      #1;
      checkOutput("rr_full_ready", 32'(req_ready), 32'h0);

      $display("[TB] asynchronous reset mid-traffic");
      rst_n = 1'b0;
      #1;
      checkOutput("async_mult_valid", 32'(mult_valid), 32'h0);
      checkOutput("async_ready",      32'(req_ready), 32'h0);
      checkOutput("async_mult_a",     32'(mult_a), 32'h0);
      step();
      rst_n = 1'b1;
      #1;
      checkOutput("post_rst_grant", 32'(req_ready), 32'h1);

      $display("[TB] single requester 2");
      doReset();
      applyStimulus(4'b0100, {8'd40, 8'd30, 8'd20, 8'd10}, '0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput($sformatf("solo_grant%0d", k), 32'(req_ready), 32'h4);
         step();
      end

      $display("[TB] product routing");
      doReset();
      applyStimulus(4'b0010, {8'd200, 8'd0, 8'd3, 8'd0}, {8'd200, 8'd0, 8'd5, 8'd0}, 1'b0, '0, 1'b0);
      #1;
      checkOutput("route_ready1", 32'(req_ready), 32'h2);
      step();
      checkOutput("route_mult_a1", 32'(mult_a), 32'd3);
      checkOutput("route_mult_b1", 32'(mult_b), 32'd5);
      req_valid = 4'b1000;
      #1;
      checkOutput("route_ready3", 32'(req_ready), 32'h8);
      step();
      checkOutput("route_mult_a3", 32'(mult_a), 32'd200);
      applyStimulus('0, '0, '0, 1'b1, 16'd15, 1'b0);
      step();
      checkOutput("route_resp_small", 32'(resp_valid), 32'h2);
      checkOutput("route_prod_small", 32'(resp_product), 32'd15);
      checkOutput("route_idle_mult_valid", 32'(mult_valid), 32'h0);
      mult_product_valid = 1'b0;
      mult_product = 16'hdead;
      for (int k = 0; k < 3; k++) step();
      checkOutput("route_gap_resp", 32'(resp_valid), 32'h0);
      checkOutput("route_gap_hold", 32'(resp_product), 32'd15);
      applyStimulus('0, '0, '0, 1'b1, 16'd40000, 1'b0);
      step();
      checkOutput("route_resp_big", 32'(resp_valid), 32'h8);
      checkOutput("route_prod_big", 32'(resp_product), 32'd40000);

      $display("[TB] full credit");
      doReset();
      applyStimulus(4'b1111, '0, '0, 1'b0, '0, 1'b0);
      for (int k = 0; k < MAX_OUT; k++) step();
      checkOutput("full_ready", 32'(req_ready), 32'h0);
      mult_product_valid = 1'b1;
      mult_product = 16'h0111;
      #1;
      checkOutput("full_pop_ready", 32'(req_ready), 32'h0);
      step();
      checkOutput("full_pop_resp", 32'(resp_valid), 32'h1);
      mult_product = 16'h0222;
      #1;
      checkOutput("pushpop_ready", 32'(req_ready), 32'h1);
      step();
      checkOutput("pushpop_resp", 32'(resp_valid), 32'h2);
      checkOutput("pushpop_prod", 32'(resp_product), 32'h0222);
      mult_product_valid = 1'b0;
      #1;
      checkOutput("refill_ready", 32'(req_ready), 32'h2);
      step();
      checkOutput("count_unchanged", 32'(req_ready), 32'h0);

      $display("[TB] drain");
      doReset();
      applyStimulus(4'b0001, '0, '0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 3; k++) step();
      applyStimulus(4'b1111, '0, '0, 1'b0, '0, 1'b1);
      #1;
      checkOutput("drain_req_ready", 32'(req_ready), 32'h0);
      step();
      checkOutput("drain_mult_valid", 32'(mult_valid), 32'h0);
      checkOutput("drain_not_yet", 32'(drained), 32'h0);
      mult_product_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("drain_ready%0d", k), 32'(req_ready), 32'h0);
         step();
      end
      checkOutput("drain_last_resp", 32'(resp_valid), 32'h1);
      checkOutput("drain_at_resp", 32'(drained), 32'h0);
      mult_product_valid = 1'b0;
      step();
      checkOutput("drained_high", 32'(drained), 32'h1);
      checkOutput("drained_ready", 32'(req_ready), 32'h0);
      drain = 1'b0;
      #1;
      checkOutput("undrain_same_cycle", 32'(req_ready), 32'h0);
      step();
      checkOutput("undrain_drained", 32'(drained), 32'h0);
      checkOutput("undrain_ready", 32'(req_ready), 32'h2);

      $display("[TB] empty pop");
      doReset();
      applyStimulus('0, '0, '0, 1'b1, 16'h1234, 1'b0);
      step();
      checkOutput("err_set", 32'(tag_err), 32'h1);
      checkOutput("err_no_resp", 32'(resp_valid), 32'h0);
      applyStimulus(4'b1111, '0, '0, 1'b0, '0, 1'b0);
      step();
      checkOutput("err_sticky", 32'(tag_err), 32'h1);
      checkOutput("err_count_zero", 32'(req_ready), 32'h2);
      rst_n = 1'b0;
      #1;
      checkOutput("err_cleared", 32'(tag_err), 32'h0);
      step();
      rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
